// File: rtl/multdiv_unit_if.sv
// Start/operand/result bundle between the execute stage and multdiv_unit.
// master drives starts and operands; slave returns result and status.
interface multdiv_unit_if;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output ctrl_MULT, ctrl_DIV,
        output data_operandA, data_operandB,
        input  data_result, data_exception,
        input  data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV,
        input  data_operandA, data_operandB,
        output data_result, data_exception,
        output data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit radix-4 Booth multiplier with optional
// non-restoring divider (compiled in when MULTDIV_DIV_EN is defined).
module multdiv_unit (
    input  logic          clock,
    input  logic          reset_n,
    multdiv_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE, MULT_RUN, DIV_RUN, DIV_FIX
    } state_t;

    state_t      r_state, w_next;
    logic        w_start, w_done;
    logic [5:0]  r_cnt;
    logic [31:0] r_mcand, r_lo, r_result;
    logic [32:0] r_up;
    logic        r_bb, r_exc, r_rdy;
    logic [33:0] w_a34, w_add, w_sum;
    logic [32:0] w_pf;
    logic        w_movf;
    logic [31:0] w_res;
    logic        w_exc;

    assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
    assign bus.busy           = (r_state != IDLE);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next state; a new start always wins and aborts any run
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        if (w_start) begin
            if (bus.ctrl_MULT) w_next = MULT_RUN;
`ifdef MULTDIV_DIV_EN
            else               w_next = DIV_RUN;
`else
            else               w_next = DIV_FIX;
`endif
        end else begin
            case (r_state)
                MULT_RUN: if (r_cnt == 6'd16) begin
                    w_next = IDLE;
                    w_done = 1'b1;
                end
`ifdef MULTDIV_DIV_EN
                DIV_RUN: if (r_cnt == 6'd32) w_next = DIV_FIX;
`endif
                DIV_FIX: begin
                    w_next = IDLE;
                    w_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Booth recode and sum; 34-bit sum keeps the sign of +2^32
    always_comb begin
        w_a34 = {{2{r_mcand[31]}}, r_mcand};
        w_add = '0;
        case ({r_lo[1:0], r_bb})
            3'b001, 3'b010: w_add = w_a34;
            3'b011:         w_add = w_a34 << 1;
            3'b100:         w_add = -(w_a34 << 1);
            3'b101, 3'b110: w_add = -w_a34;
            default:        w_add = '0;
        endcase
        w_sum  = {r_up[32], r_up} + w_add;
        w_pf   = {r_up[31:0], r_lo[31]};
        w_movf = !((&w_pf) || !(|w_pf));
    end

    // Multiply datapath and shared iteration counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_up    <= '0;
            r_lo    <= '0;
            r_bb    <= 1'b0;
        end else if (w_start) begin
            r_cnt   <= '0;
            r_mcand <= bus.data_operandA;
            r_up    <= '0;
            r_lo    <= bus.data_operandB;
            r_bb    <= 1'b0;
        end else if (r_state == MULT_RUN && r_cnt != 6'd16) begin
            r_up  <= {w_sum[33], w_sum[33:2]};
            r_lo  <= {w_sum[1:0], r_lo[31:2]};
            r_bb  <= r_lo[1];
            r_cnt <= r_cnt + 6'd1;
        end else if (r_state == DIV_RUN) begin
            r_cnt <= r_cnt + 6'd1;
        end
    end

`ifdef MULTDIV_DIV_EN
    logic [32:0] r_rem;
    logic [31:0] r_quo, r_dvs;
    logic        r_neg, r_dz, r_dexc;
    logic [31:0] w_amag, w_bmag;
    logic [33:0] w_sh, w_rnew;

    // Magnitudes and one non-restoring step
    always_comb begin
        w_amag = bus.data_operandA[31] ? -bus.data_operandA
                                       : bus.data_operandA;
        w_bmag = bus.data_operandB[31] ? -bus.data_operandB
                                       : bus.data_operandB;
        w_sh   = {r_rem, r_quo[31]};
        w_rnew = r_rem[32] ? w_sh + {2'b00, r_dvs}
                           : w_sh - {2'b00, r_dvs};
    end

    // Divide datapath; quotient shifts in as dividend shifts out
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_neg  <= 1'b0;
            r_dz   <= 1'b0;
            r_dexc <= 1'b0;
        end else if (w_start) begin
            r_rem  <= '0;
            r_quo  <= w_amag;
            r_dvs  <= w_bmag;
            r_neg  <= bus.data_operandA[31] ^ bus.data_operandB[31];
            r_dz   <= (bus.data_operandB == 32'd0);
            r_dexc <= (bus.data_operandB == 32'd0) ||
                      (bus.data_operandA == 32'h8000_0000 &&
                       bus.data_operandB == 32'hFFFF_FFFF);
        end else if (r_state == DIV_RUN) begin
            if (r_cnt != 6'd32) begin
                r_rem <= w_rnew[32:0];
                r_quo <= {r_quo[30:0], ~w_rnew[33]};
            end else begin
                if (r_rem[32]) r_rem <= r_rem + {1'b0, r_dvs};
                if (r_dz)       r_quo <= '0;
                else if (r_neg) r_quo <= -r_quo;
            end
        end
    end
`endif

    // Completion value select
    always_comb begin
        w_res = r_lo;
        w_exc = w_movf;
        if (r_state == DIV_FIX) begin
`ifdef MULTDIV_DIV_EN
            w_res = r_quo;
            w_exc = r_dexc;
`else
            w_res = '0;
            w_exc = 1'b1;
`endif
        end
    end

    // Registered outputs; result/exception hold between completions
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= w_done;
            if (w_done) begin
                r_result <= w_res;
                r_exc    <= w_exc;
            end
        end
    end
endmodule
